// File: rtl/mem_access_sequencer_pkg.sv
// Shared encodings for the load/store sequencer: Func_3 size codes, FSM states,
// fault codes and the store-lane / legality helpers used at request latch time.
package mem_access_sequencer_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_RESP  = 3'd2,
      S_DONE  = 3'd3,
      S_FAULT = 3'd4
   } seq_state_t;

   localparam logic [1:0] FC_MISALIGN = 2'd0;
   localparam logic [1:0] FC_ILLEGAL  = 2'd1;
   localparam logic [1:0] FC_TIMEOUT  = 2'd2;

   // Unsigned sizes only exist for loads; stores accept B/H/W.
   function automatic logic func3_legal(input logic [2:0] f3, input logic is_store);
      case (f3)
         F3_B, F3_H, F3_W: return 1'b1;
         F3_BU, F3_HU:     return !is_store;
         default:          return 1'b0;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
   endfunction

   function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b00:   return 4'b0001 << lo;
         2'b01:   return 4'b0011 << lo;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
      case (f3[1:0])
         2'b00:   return {4{sd[7:0]}};
         2'b01:   return {2{sd[15:0]}};
         default: return sd;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Data-memory request/response bus between the sequencer (master) and memory (slave).
// Handshake: a request transfers on a cycle with mem_valid & mem_ready; the payload
// (mem_we/addr/wdata/wstrb) is stable while mem_valid is high; mem_rsp_valid marks
// read data or write acknowledge for the single outstanding request.
interface mem_access_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic              mem_valid;
   logic              mem_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic              mem_rsp_valid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rsp_valid, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rsp_valid, mem_rdata
   );
endinterface

// File: rtl/mem_access_sequencer_load_align.sv
// Load lane selection: picks the addressed byte/half of a read word and
// sign- or zero-extends it according to Func_3.
module load_align_unit
   import mem_access_sequencer_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  byte_sel,
   input  logic [2:0]  func3,
   output logic [31:0] data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      sel_byte = word[{byte_sel, 3'b000} +: 8];
      sel_half = byte_sel[1] ? word[31:16] : word[15:0];
      case (func3)
         F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
         F3_H:    data = {{16{sel_half[15]}}, sel_half};
         F3_BU:   data = {24'h0, sel_byte};
         F3_HU:   data = {16'h0, sel_half};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store controller: stalls the core while one data-memory access
// is issued, waited on and completed, and reports misalignment/illegal/timeout faults.
module mem_access_sequencer
   import mem_access_sequencer_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 MEM_Extract,
   input  logic                 MEM_Store,
   input  logic [2:0]           Func_3,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [31:0]          store_data,
   output logic                 stall,
   output logic [31:0]          load_data,
   output logic                 done,
   output logic                 fault,
   output logic [1:0]           fault_code,
   output seq_state_t           dbg_state,
   mem_access_sequencer_if.master bus
);

   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   seq_state_t       state;
   logic [2:0]       f3_q;
   logic [1:0]       addr_lo_q;
   logic [TMO_W-1:0] tmo_cnt;
   logic [31:0]      aligned;
   logic             request;
   logic             tmo_hit;

   assign request   = MEM_Extract | MEM_Store;
   assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
   assign stall     = (request && (state == S_IDLE)) || (state == S_REQ) || (state == S_RESP);
   assign dbg_state = state;

   load_align_unit u_align (
      .word     (bus.mem_rdata),
      .byte_sel (addr_lo_q),
      .func3    (f3_q),
      .data     (aligned)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         f3_q          <= '0;
         addr_lo_q     <= '0;
         tmo_cnt       <= '0;
         load_data     <= '0;
         done          <= 1'b0;
         fault         <= 1'b0;
         fault_code    <= '0;
         bus.mem_valid <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= '0;
      end else begin
         done  <= 1'b0;
         fault <= 1'b0;
         case (state)
            S_IDLE: begin
               if (request) begin
                  f3_q          <= Func_3;
                  addr_lo_q     <= addr[1:0];
                  tmo_cnt       <= '0;
                  bus.mem_we    <= MEM_Store;
                  bus.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  bus.mem_wdata <= store_lanes(Func_3, store_data);
                  bus.mem_wstrb <= MEM_Store ? store_strb(Func_3, addr[1:0]) : 4'b0000;
                  // Legality is judged before alignment: an illegal size has no alignment.
                  if ((MEM_Extract && MEM_Store) || !func3_legal(Func_3, MEM_Store)) begin
                     state      <= S_FAULT;
                     fault      <= 1'b1;
                     fault_code <= FC_ILLEGAL;
                  end else if (misaligned(Func_3, addr[1:0])) begin
                     state      <= S_FAULT;
                     fault      <= 1'b1;
                     fault_code <= FC_MISALIGN;
                  end else begin
                     state         <= S_REQ;
                     bus.mem_valid <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               // A handshake landing on the final budget cycle still wins over the timeout.
               if (bus.mem_ready) begin
                  state         <= S_RESP;
                  bus.mem_valid <= 1'b0;
                  tmo_cnt       <= tmo_cnt + TMO_W'(1);
               end else if (tmo_hit) begin
                  state         <= S_FAULT;
                  bus.mem_valid <= 1'b0;
                  fault         <= 1'b1;
                  fault_code    <= FC_TIMEOUT;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            S_RESP: begin
               if (bus.mem_rsp_valid) begin
                  if (!bus.mem_we) load_data <= aligned;
                  state <= S_DONE;
                  done  <= 1'b1;
               end else if (tmo_hit) begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= FC_TIMEOUT;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            S_FAULT: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed load/store/fault scenarios
// plus a randomized back-to-back run, with results checked through an expected queue.
module tb_mem_access_sequencer;
   import mem_access_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_Extract, MEM_Store;
   logic [2:0]  Func_3;
   logic [31:0] addr, store_data;
   logic        stall, done, fault;
   logic [31:0] load_data;
   logic [1:0]  fault_code;
   seq_state_t  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_load;
   logic [35:0] exp_q[$];

   mem_access_sequencer_if #(.ADDR_W(32)) bus ();

   mem_access_sequencer #(.ADDR_W(32), .TIMEOUT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .MEM_Extract (MEM_Extract),
      .MEM_Store   (MEM_Store),
      .Func_3      (Func_3),
      .addr        (addr),
      .store_data  (store_data),
      .stall       (stall),
      .load_data   (load_data),
      .done        (done),
      .fault       (fault),
      .fault_code  (fault_code),
      .dbg_state   (dbg_state),
      .bus         (bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // result word: {done, fault, fault_code, load_data}
   function automatic logic [35:0] res_done(input logic [31:0] d);
      return {1'b1, 1'b0, 2'b00, d};
   endfunction

   function automatic logic [35:0] res_fault(input logic [1:0] code, input logic [31:0] d);
      return {1'b0, 1'b1, code, d};
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3);
      logic [31:0] sh;
      sh = w >> (off * 8);
      case (f3)
         3'b000:  return 32'($signed(sh[7:0]));
         3'b001:  return 32'($signed(sh[15:0]));
         3'b100:  return {24'h0, sh[7:0]};
         3'b101:  return {16'h0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   // driver: issues one access, plays the memory, and scores the completion pulse
   task automatic run_access(input logic ext, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             input logic [31:0] rdata, input int ready_wait,
                             input logic [35:0] exp_res, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata,
                             output int stall_cyc, output int valid_cyc);
      int   waited;
      logic accepted;
      logic finished;
      logic payload_seen;
      logic [35:0] got, want;
      exp_q.push_back(exp_res);
      @(negedge clk);
      MEM_Extract = ext; MEM_Store = st; Func_3 = f3; addr = a; store_data = sd;
      bus.mem_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
      stall_cyc = 0; valid_cyc = 0; waited = 0;
      accepted = 1'b0; finished = 1'b0; payload_seen = 1'b0;
      for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
         #1;
         bus.mem_rsp_valid = 1'b0;
         if (accepted) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = rdata;
            accepted          = 1'b0;
         end
         if (done || fault) begin
            got  = {done, fault, fault ? fault_code : 2'b00, load_data};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL result addr=%h f3=%b: got %h expected %h", a, f3, got, want);
            end
            MEM_Extract = 1'b0; MEM_Store = 1'b0; bus.mem_ready = 1'b0;
            finished = 1'b1;
         end else begin
            if (stall) stall_cyc++;
            bus.mem_ready = 1'b0;
            if (bus.mem_valid) begin
               valid_cyc++;
               if (!payload_seen) begin
                  payload_seen = 1'b1;
                  checks++;
                  if (bus.mem_addr !== {a[31:2], 2'b00} || bus.mem_we !== st ||
                      bus.mem_wstrb !== exp_strb || (st && bus.mem_wdata !== exp_wdata)) begin
                     errors++;
                     $display("FAIL payload addr=%h: got a=%h we=%b strb=%b wd=%h expected a=%h we=%b strb=%b wd=%h",
                              a, bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata,
                              {a[31:2], 2'b00}, st, exp_strb, exp_wdata);
                  end
               end
               if (waited >= ready_wait) begin
                  bus.mem_ready = 1'b1;
                  accepted      = 1'b1;
               end else begin
                  waited++;
               end
            end
            @(negedge clk);
         end
      end
      if (!finished) begin
         checks++; errors++;
         $display("FAIL completion addr=%h: no done/fault within 40 cycles", a);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         MEM_Extract = 1'b0; MEM_Store = 1'b0; bus.mem_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      MEM_Extract = 1'b0; MEM_Store = 1'b0; Func_3 = 3'b000; addr = '0; store_data = '0;
      bus.mem_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (dbg_state !== S_IDLE) begin
         errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
      end
      checks++;
      if ({stall, done, fault, fault_code} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 00000", {stall, done, fault, fault_code});
      end
      checks++;
      if (bus.mem_valid !== 1'b0 || bus.mem_wstrb !== 4'b0 || bus.mem_we !== 1'b0 || load_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus: got valid=%b strb=%b we=%b ld=%h expected all zero",
                  bus.mem_valid, bus.mem_wstrb, bus.mem_we, load_data);
      end
      rst = 1'b0;
      last_load = 32'h0;
   endtask

   task automatic test_lw;
      int sc, vc;
      run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0,
                 res_done(32'hDEAD_BEEF), 4'b0000, 32'h0, sc, vc);
      last_load = 32'hDEAD_BEEF;
      checks++;
      if (sc != 3) begin errors++; $display("FAIL lw_stall: got %0d expected 3", sc); end
      checks++;
      if (vc != 1) begin errors++; $display("FAIL lw_valid_cycles: got %0d expected 1", vc); end
   endtask

   task automatic test_lb_lbu;
      int sc, vc;
      run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0,
                 res_done(32'hFFFF_FF80), 4'b0000, 32'h0, sc, vc);
      run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 0,
                 res_done(32'h0000_0080), 4'b0000, 32'h0, sc, vc);
      run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h9ABC_1234, 1,
                 res_done(32'hFFFF_9ABC), 4'b0000, 32'h0, sc, vc);
      last_load = 32'hFFFF_9ABC;
      checks++;
      if (sc != 4) begin errors++; $display("FAIL lh_wait_stall: got %0d expected 4", sc); end
   endtask

   task automatic test_sh;
      int sc, vc;
      run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 2,
                 res_done(last_load), 4'b1100, 32'hABCD_ABCD, sc, vc);
      checks++;
      if (sc != 5 || vc != 3) begin
         errors++; $display("FAIL sh_timing: got stall=%0d valid=%0d expected stall=5 valid=3", sc, vc);
      end
   endtask

   task automatic test_faults;
      int sc, vc;
      logic [2:0]  f3_t[6]  = '{3'b010, 3'b101, 3'b010, 3'b011, 3'b100, 3'b011};
      logic [31:0] a_t[6]   = '{32'h101, 32'h103, 32'h102, 32'h300, 32'h300, 32'h101};
      logic        st_t[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        ex_t[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [1:0]  fc_t[6]  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
      for (int i = 0; i < 6; i++) begin
         run_access(ex_t[i], st_t[i], f3_t[i], a_t[i], 32'h5555_AAAA, 32'h0, 0,
                    res_fault(fc_t[i], last_load), 4'b0000, 32'h0, sc, vc);
         checks++;
         if (sc != 1 || vc != 0) begin
            errors++; $display("FAIL fault_shape[%0d]: got stall=%0d valid=%0d expected stall=1 valid=0", i, sc, vc);
         end
      end
      // both operations asserted together
      run_access(1'b1, 1'b1, 3'b010, 32'h400, 32'h0, 32'h0, 0,
                 res_fault(2'd1, last_load), 4'b0000, 32'h0, sc, vc);
   endtask

   task automatic test_timeout;
      int sc, vc;
      run_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 1000,
                 res_fault(2'd2, last_load), 4'b0000, 32'h0, sc, vc);
      checks++;
      if (vc != 4 || sc != 5) begin
         errors++; $display("FAIL timeout_shape: got valid=%0d stall=%0d expected valid=4 stall=5", vc, sc);
      end
      #1;
      checks++;
      if (bus.mem_valid !== 1'b0) begin
         errors++; $display("FAIL timeout_valid_drop: got %b expected 0", bus.mem_valid);
      end
   endtask

   task automatic test_back_to_back;
      int sc, vc;
      logic [2:0]  ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] a, sd, rd, exp_wd;
      logic [3:0]  exp_st;
      logic        is_st;
      for (int i = 0; i < 14; i++) begin
         is_st = 1'($urandom_range(0, 1));
         f3    = is_st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
         case (f3[1:0])
            2'b00:   off = 2'($urandom_range(0, 3));
            2'b01:   off = {1'($urandom_range(0, 1)), 1'b0};
            default: off = 2'b00;
         endcase
         a  = 32'h1000 + 32'($urandom_range(0, 255)) * 4 + 32'(off);
         sd = $urandom;
         rd = $urandom;
         if (is_st) begin
            case (f3[1:0])
               2'b00:   begin exp_wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]}; exp_st = 4'(1 << off); end
               2'b01:   begin exp_wd = {sd[15:0], sd[15:0]}; exp_st = 4'(3 << off); end
               default: begin exp_wd = sd; exp_st = 4'hF; end
            endcase
            run_access(1'b0, 1'b1, f3, a, sd, rd, $urandom_range(0, 2),
                       res_done(last_load), exp_st, exp_wd, sc, vc);
         end else begin
            run_access(1'b1, 1'b0, f3, a, sd, rd, $urandom_range(0, 2),
                       res_done(model_load(rd, off, f3)), 4'b0000, 32'h0, sc, vc);
            last_load = model_load(rd, off, f3);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic pulse_seen;
      @(negedge clk);
      MEM_Extract = 1'b1; Func_3 = 3'b010; addr = 32'h200; bus.mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (dbg_state !== S_RESP) begin
         errors++; $display("FAIL mid_reach_resp: got %0d expected %0d", dbg_state, S_RESP);
      end
      bus.mem_ready = 1'b0; rst = 1'b1;
      @(negedge clk);
      checks++;
      if (dbg_state !== S_IDLE || bus.mem_valid !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL mid_reset: got state=%0d valid=%b done=%b expected 0 0 0",
                            dbg_state, bus.mem_valid, done);
      end
      rst = 1'b0; MEM_Extract = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h1234_5678;
      pulse_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done || fault || stall) pulse_seen = 1'b1;
      end
      bus.mem_rsp_valid = 1'b0;
      last_load = 32'h0;
      checks++;
      if (pulse_seen || load_data !== last_load) begin
         errors++; $display("FAIL mid_late_rsp: got pulse=%b load_data=%h expected 0 %h",
                            pulse_seen, load_data, last_load);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lb_lbu();
      test_sh();
      test_faults();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_lw();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
